oldland_dbus_ram: RTL and testbench

On-chip data RAM that acts as the responder on the Oldland data bus. It serves the load/store requests issued by the memory stage. Each request is decoded against a configurable base window, stored in a synchronous RAM with byte-lane write enables, and completed with a single-cycle `d_ack` carrying registered read data. Addresses outside the window get a single-cycle `d_error`. Wait states are configurable so that slower memories can be modelled.

---
 rtl/oldland_dbus_ram_if.sv | 22 ++
 rtl/oldland_dbus_ram.sv | 114 +++++++++++
 tb/tb_oldland_dbus_ram.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/oldland_dbus_ram_if.sv
// Oldland data bus: memory-stage initiator to data RAM responder.
// Request fields are held by the initiator until completion.
interface oldland_dbus_ram_if;
    logic        d_access;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;

    modport master (
        output d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        input  d_data, d_ack, d_error
    );

    modport slave (
        input  d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        output d_data, d_ack, d_error
    );
endinterface

// File: rtl/oldland_dbus_ram.sv
// On-chip data RAM responding on the Oldland data bus: windowed decode,
// byte-lane writes, registered read data and configurable wait states.
module oldland_dbus_ram #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE        = 32'h00000000,
    parameter int          WAIT_STATES = 0
) (
    input logic               clk,
    input logic               rst,
    oldland_dbus_ram_if.slave bus
);
    localparam int         DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [3:0]             be_q;
    logic                   wr_q;
    logic [31:0]            wval_q;
    logic                   capture, do_acc, in_range;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   acc_wr;
    logic [3:0]             acc_be;
    logic [31:0]            acc_wval;
    logic [31:0]            data_q;
    logic                   ack_q, err_q;
    logic                   unused_addr;

    logic [3:0][7:0]        mem [0:DEPTH-1];

    assign in_range    = bus.d_addr[31:ADDR_BITS+2] == BASE[31:ADDR_BITS+2];
    assign unused_addr = ^bus.d_addr[1:0];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        capture  = 1'b0;
        do_acc   = 1'b0;
        acc_idx  = idx_q;
        acc_wr   = wr_q;
        acc_be   = be_q;
        acc_wval = wval_q;
        case (state)
            IDLE: if (bus.d_access) begin
                capture = 1'b1;
                if (!in_range) begin
                    state_n = ERR;
                end else if (WS == 4'd0) begin
                    // Zero wait states: access straight from the bus, registers not loaded yet.
                    do_acc   = 1'b1;
                    acc_idx  = bus.d_addr[ADDR_BITS+1:2];
                    acc_wr   = bus.d_wr_en;
                    acc_be   = bus.d_bytesel;
                    acc_wval = bus.d_wr_val;
                    state_n  = RESP;
                end else begin
                    cnt_n   = WS;
                    state_n = WAIT;
                end
            end
            WAIT: if (cnt == 4'd1) begin
                do_acc  = 1'b1;
                cnt_n   = 4'd0;
                state_n = RESP;
            end else begin
                cnt_n = cnt - 4'd1;
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            idx_q  <= '0;
            be_q   <= 4'd0;
            wr_q   <= 1'b0;
            wval_q <= 32'd0;
            data_q <= 32'd0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                idx_q  <= bus.d_addr[ADDR_BITS+1:2];
                be_q   <= bus.d_bytesel;
                wr_q   <= bus.d_wr_en;
                wval_q <= bus.d_wr_val;
            end
            ack_q  <= state_n == RESP;
            err_q  <= state_n == ERR;
            data_q <= (do_acc && !acc_wr) ? mem[acc_idx] : 32'd0;
        end
    end

    // Storage is deliberately left out of reset; writes are still blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && do_acc && acc_wr) begin
            for (int b = 0; b < 4; b++)
                if (acc_be[b]) mem[acc_idx][b] <= acc_wval[8*b +: 8];
        end
    end

    assign bus.d_data  = data_q;
    assign bus.d_ack   = ack_q;
    assign bus.d_error = err_q;
endmodule

// File: tb/tb_oldland_dbus_ram.sv
// Randomized bench for oldland_dbus_ram: one instance with no wait states,
// one with two, both checked against a word-array model of the bus rules.
module tb_oldland_dbus_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oldland_dbus_ram_if bus0();
    oldland_dbus_ram_if bus2();

    oldland_dbus_ram #(.ADDR_BITS(10), .BASE(32'h0), .WAIT_STATES(0)) u_ram0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    oldland_dbus_ram #(.ADDR_BITS(10), .BASE(32'h0), .WAIT_STATES(2)) u_ram2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem2 [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input bit acc, input logic [31:0] a, input bit w,
                         input logic [3:0] be, input logic [31:0] v);
        if (s) begin
            bus2.d_access = acc; bus2.d_addr = a; bus2.d_wr_en = w;
            bus2.d_bytesel = be; bus2.d_wr_val = v;
        end else begin
            bus0.d_access = acc; bus0.d_addr = a; bus0.d_wr_en = w;
            bus0.d_bytesel = be; bus0.d_wr_val = v;
        end
    endtask

    task automatic obs(input bit s, output logic ack, output logic err, output logic [31:0] d);
        ack = s ? bus2.d_ack   : bus0.d_ack;
        err = s ? bus2.d_error : bus0.d_error;
        d   = s ? bus2.d_data  : bus0.d_data;
    endtask

    // One full transaction; expectations come from the window rule and the word model.
    task automatic txn(input bit s, input logic [31:0] a, input bit w, input logic [3:0] be,
                       input logic [31:0] v, input bit perturb);
        bit          inr, done;
        int          idx, lat, cyc;
        logic [31:0] exp_d, old, nw;
        logic        ack, err;
        logic [31:0] d;
        inr   = (a[31:12] == 20'd0);
        idx   = int'(a[11:2]);
        lat   = inr ? 1 + (s ? 2 : 0) : 1;
        old   = s ? mem2[idx] : mem0[idx];
        exp_d = (inr && !w) ? old : 32'd0;
        done  = 1'b0;
        cyc   = 0;
        drive(s, 1'b1, a, w, be, v);
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            obs(s, ack, err, d);
            chk("ack_err_excl", 32'(ack & err), 32'd0);
            if (ack || err) begin
                done = 1'b1;
                chk("latency", cyc, lat);
                chk("ack", 32'(ack), 32'(inr));
                chk("error", 32'(err), 32'(!inr));
                chk("rdata", d, exp_d);
                drive(s, 1'b0, $urandom, $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
            end else begin
                chk("data_wait", d, 32'd0);
                if (perturb)
                    drive(s, 1'b1, $urandom, $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
            end
        end
        if (!done) begin
            chk("timeout", cyc, lat);
            drive(s, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        end
        if (inr && w) begin
            nw = old;
            for (int b = 0; b < 4; b++)
                if (be[b]) nw[8*b +: 8] = v[8*b +: 8];
            if (s) mem2[idx] = nw; else mem0[idx] = nw;
        end
        @(posedge clk); #1;
        obs(s, ack, err, d);
        chk("after_done", {d[29:0], ack, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ack, err;
        logic [31:0] d, a;
        int          last, nack;
        bit          s;

        // Reset held 2 cycles with requests pending on both instances.
        drive(1'b0, 1'b1, 32'h10, 1'b1, 4'hF, 32'hCAFEF00D);
        drive(1'b1, 1'b1, 32'h10, 1'b1, 4'hF, 32'hCAFEF00D);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                rst = 1'b0;
                drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
                drive(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            end
            for (int k = 0; k < 2; k++) begin
                obs(k == 1, ack, err, d);
                chk("reset_ack", 32'(ack), 32'd0);
                chk("reset_err", 32'(err), 32'd0);
                chk("reset_data", d, 32'd0);
            end
        end

        // Give every word the tests touch a known value.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                txn(k == 1, 32'(i * 4), 1'b1, 4'hF, $urandom, 1'b0);

        // Directed: word write/read, byte lanes, empty bytesel.
        txn(1'b0, 32'h10, 1'b1, 4'hF, 32'h11223344, 1'b0);
        txn(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
        chk("word_rw_model", mem0[4], 32'h11223344);
        txn(1'b0, 32'h10, 1'b1, 4'b0100, 32'h00AB0000, 1'b0);
        txn(1'b0, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b0);
        txn(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
        chk("lane_model", mem0[4], 32'h11AB3344);

        // Out of window: error, and no write lands on the aliased word 0.
        txn(1'b0, 32'h00001000, 1'b0, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h00001000, 1'b1, 4'hF, 32'h5A5A5A5A, 1'b0);
        txn(1'b0, 32'h00000000, 1'b0, 4'hF, 32'h0, 1'b0);
        txn(1'b1, 32'h80000010, 1'b1, 4'hF, 32'h5A5A5A5A, 1'b1);

        // Wait states with request inputs scrambled during the wait.
        txn(1'b1, 32'h14, 1'b1, 4'hF, 32'h0BADBEEF, 1'b1);
        txn(1'b1, 32'h14, 1'b0, 4'hF, 32'h0, 1'b1);

        // Held access: completions every 4 cycles.
        drive(1'b1, 1'b1, 32'h14, 1'b0, 4'hF, 32'h0);
        last = -1;
        nack = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            obs(1'b1, ack, err, d);
            if (ack) begin
                nack++;
                chk("b2b_gap", c - last, 4);
                chk("b2b_data", d, mem2[5]);
                last = c;
                if (c > 12) drive(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            end
        end
        chk("b2b_count", nack, 4);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #1;

        // Reset on the commit edge of a waited write: no ack, old data kept.
        drive(1'b1, 1'b1, 32'h20, 1'b1, 4'hF, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        obs(1'b1, ack, err, d);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            obs(1'b1, ack, err, d);
            chk("rst_mid_quiet", {d[29:0], ack, err}, 32'd0);
        end
        txn(1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 1'b0);

        // Random mix on both instances.
        for (int i = 0; i < 120; i++) begin
            s = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0)
                a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
            else
                a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            txn(s, a, $urandom_range(0, 1) == 1, 4'($urandom), $urandom, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
